// File: rtl/aes_pkg.sv
// Shared AES definitions: key-schedule state encoding, round-constant values
// and small word-level helpers used by the key expansion datapath.
package aes_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        READY = 3'd1,
        SUB   = 3'd2,
        MIX   = 3'd3,
        DONE  = 3'd4
    } key_state_t;

    localparam logic [7:0] RCON_INIT     = 8'h01;
    localparam logic [7:0] RCON_POLY     = 8'h1b;
    localparam int         AES128_ROUNDS = 10;

    // Multiply by x in GF(2^8) modulo the AES polynomial.
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? RCON_POLY : 8'h00);
    endfunction

    function automatic logic [31:0] rot_word(input logic [31:0] w);
        return {w[23:0], w[31:24]};
    endfunction

endpackage

// File: rtl/aes_sbox.sv
// Forward AES S-box, purely combinational 8-bit lookup.
module aes_sbox (
    input  logic [7:0] in_byte,
    output logic [7:0] out_byte
);

    // Entry 0 occupies the most significant byte of the table.
    localparam logic [2047:0] SBOX_TABLE = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    assign out_byte = SBOX_TABLE[11'd2047 - {in_byte, 3'b000} -: 8];

endmodule

// File: rtl/key_schedule_iter.sv
// Iterative AES-128 key expansion: produces one round key per request using
// a two-cycle SUB/MIX sequence and a single shared SubWord datapath.
module key_schedule_iter
    import aes_pkg::*;
#(
    parameter int NUM_ROUNDS = AES128_ROUNDS
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         start,
    input  logic [127:0] cipher_key,
    input  logic         req_key,
    output logic [127:0] round_key,
    output logic         key_valid,
    output logic [3:0]   round_num,
    output logic         last_key,
    output logic         err
);

    localparam logic [3:0] LAST_NUM = 4'(NUM_ROUNDS);

    key_state_t  state;
    logic [31:0] temp_p1;
    logic [7:0]  rcon;
    logic [31:0] rot_w3;
    logic [31:0] sub_w3;
    logic [31:0] w0_n, w1_n, w2_n, w3_n;
    logic [3:0]  next_num;

    assign rot_w3 = rot_word(round_key[31:0]);

    for (genvar i = 0; i < 4; i++) begin : g_sbox
        aes_sbox u_sbox (
            .in_byte  (rot_w3[8*i +: 8]),
            .out_byte (sub_w3[8*i +: 8])
        );
    end

    assign w0_n     = round_key[127:96] ^ temp_p1;
    assign w1_n     = round_key[95:64]  ^ w0_n;
    assign w2_n     = round_key[63:32]  ^ w1_n;
    assign w3_n     = round_key[31:0]   ^ w2_n;
    assign next_num = round_num + 4'd1;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            round_key <= '0;
            temp_p1   <= '0;
            rcon      <= RCON_INIT;
            round_num <= '0;
            key_valid <= 1'b0;
            last_key  <= 1'b0;
            err       <= 1'b0;
        end else if (start) begin
            // Start wins over a coincident req_key, which is dropped silently.
            state     <= READY;
            round_key <= cipher_key;
            rcon      <= RCON_INIT;
            round_num <= '0;
            key_valid <= 1'b1;
            last_key  <= 1'b0;
            err       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_key) err <= 1'b1;
                end
                READY: begin
                    if (req_key) begin
                        state     <= SUB;
                        key_valid <= 1'b0;
                    end
                end
                // Stage 1: SubWord(RotWord(w3)) with round constant
                SUB: begin
                    temp_p1 <= sub_w3 ^ {rcon, 24'h0};
                    state   <= MIX;
                    if (req_key) err <= 1'b1;
                end
                // Stage 2: chained word XOR and key write-back
                MIX: begin
                    round_key <= {w0_n, w1_n, w2_n, w3_n};
                    round_num <= next_num;
                    key_valid <= 1'b1;
                    rcon      <= xtime(rcon);
                    if (next_num == LAST_NUM) begin
                        state    <= DONE;
                        last_key <= 1'b1;
                    end else begin
                        state <= READY;
                    end
                    if (req_key) err <= 1'b1;
                end
                DONE: begin
                    if (req_key) err <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_key_schedule_iter.sv
// Scoreboard bench for key_schedule_iter using FIPS-197 key expansion vectors.
module tb_key_schedule_iter;

    logic         clk = 1'b0;
    logic         reset_n;
    logic         start;
    logic [127:0] cipher_key;
    logic         req_key;
    logic [127:0] round_key;
    logic         key_valid;
    logic [3:0]   round_num;
    logic         last_key;
    logic         err;

    key_schedule_iter #(.NUM_ROUNDS(10)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .start      (start),
        .cipher_key (cipher_key),
        .req_key    (req_key),
        .round_key  (round_key),
        .key_valid  (key_valid),
        .round_num  (round_num),
        .last_key   (last_key),
        .err        (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [127:0] key;
        logic [3:0]   num;
        logic         last;
        int           due;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    localparam logic [127:0] KEY_A = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] KEY_B = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] KEY_B_RK1 = 128'hd6aa74fdd2af72fadaa678f1d6ab76fe;

    logic [127:0] rk_a [0:10];
    initial begin
        rk_a[0]  = KEY_A;
        rk_a[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
        rk_a[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
        rk_a[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
        rk_a[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
        rk_a[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
        rk_a[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
        rk_a[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
        rk_a[8]  = 128'head27321b58dbad2312bf5607f8d292f;
        rk_a[9]  = 128'hac7766f319fadc2128d12941575c006e;
        rk_a[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: a new key is presented when key_valid rises or the key/index changes.
    logic [127:0] prev_key = '0;
    logic [3:0]   prev_num = '0;
    logic         prev_vld = 1'b0;
    always @(negedge clk) begin
        exp_t e;
        if (reset_n === 1'b1 && key_valid === 1'b1 &&
            (!prev_vld || round_key !== prev_key || round_num !== prev_num)) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_key actual=%h num=%0d required=none", round_key, round_num);
            end else begin
                e = sb.pop_front();
                check("sb_round_key", round_key, e.key);
                check("sb_round_num", 128'(round_num), 128'(e.num));
                check("sb_last_key", 128'(last_key), 128'(e.last));
                check("sb_latency_cycle", 128'(cyc), 128'(e.due));
            end
        end
        prev_key = round_key;
        prev_num = round_num;
        prev_vld = key_valid;
    end

    task automatic do_start(input logic [127:0] k);
        @(negedge clk);
        start      = 1'b1;
        cipher_key = k;
        sb.push_back('{k, 4'd0, 1'b0, cyc + 1});
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic do_req(input logic [127:0] k, input logic [3:0] n, input bit push);
        @(negedge clk);
        req_key = 1'b1;
        if (push) sb.push_back('{k, n, (n == 4'd10), cyc + 3});
        @(negedge clk);
        req_key = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [127:0] held;
        reset_n    = 1'b0;
        start      = 1'b0;
        req_key    = 1'b0;
        cipher_key = '0;
        repeat (3) @(negedge clk);
        check("rst_round_key", round_key, 128'h0);
        check("rst_key_valid", 128'(key_valid), 128'h0);
        check("rst_round_num", 128'(round_num), 128'h0);
        check("rst_last_key", 128'(last_key), 128'h0);
        check("rst_err", 128'(err), 128'h0);
        reset_n = 1'b1;
        @(negedge clk);
        check("idle_key_valid", 128'(key_valid), 128'h0);

        // Full schedule of the FIPS-197 A.1 key, requests 3 cycles apart.
        do_start(KEY_A);
        check("start_err", 128'(err), 128'h0);
        for (int i = 1; i <= 10; i++) begin
            do_req(rk_a[i], 4'(i), 1'b1);
            repeat (2) @(negedge clk);
        end
        check("done_round_num", 128'(round_num), 128'd10);
        check("done_last_key", 128'(last_key), 128'h1);
        check("done_err", 128'(err), 128'h0);
        check("done_round_key", round_key, rk_a[10]);

        // Request in DONE is ignored and flagged.
        held = round_key;
        do_req('0, 4'd0, 1'b0);
        repeat (3) @(negedge clk);
        check("done_req_hold_key", round_key, held);
        check("done_req_err", 128'(err), 128'h1);

        do_start(KEY_B);
        check("restart_err_clear", 128'(err), 128'h0);
        check("restart_last_key", 128'(last_key), 128'h0);

        // Back-to-back requests: the one landing in SUB is ignored.
        do_start(KEY_A);
        do_req(rk_a[1], 4'd1, 1'b1);
        req_key = 1'b1;
        @(negedge clk);
        req_key = 1'b0;
        repeat (3) @(negedge clk);
        check("b2b_err", 128'(err), 128'h1);
        check("b2b_round_num", 128'(round_num), 128'd1);

        // start + req_key together in READY at round 4.
        do_start(KEY_A);
        for (int i = 1; i <= 4; i++) begin
            do_req(rk_a[i], 4'(i), 1'b1);
            repeat (2) @(negedge clk);
        end
        check("pre_collide_num", 128'(round_num), 128'd4);
        @(negedge clk);
        start      = 1'b1;
        req_key    = 1'b1;
        cipher_key = KEY_B;
        sb.push_back('{KEY_B, 4'd0, 1'b0, cyc + 1});
        @(negedge clk);
        start   = 1'b0;
        req_key = 1'b0;
        check("collide_err", 128'(err), 128'h0);
        repeat (3) @(negedge clk);
        check("collide_round_num", 128'(round_num), 128'd0);
        check("collide_key_valid", 128'(key_valid), 128'h1);
        check("collide_round_key", round_key, KEY_B);

        // Asynchronous reset while in MIX.
        do_start(KEY_A);
        do_req(rk_a[1], 4'd1, 1'b1);
        repeat (2) @(negedge clk);
        do_req('0, 4'd0, 1'b0);
        @(posedge clk);
        #1 reset_n = 1'b0;
        #1;
        check("arst_round_key", round_key, 128'h0);
        check("arst_round_num", 128'(round_num), 128'h0);
        check("arst_key_valid", 128'(key_valid), 128'h0);
        check("arst_last_key", 128'(last_key), 128'h0);
        check("arst_err", 128'(err), 128'h0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        repeat (4) @(negedge clk);
        check("post_rst_key_valid", 128'(key_valid), 128'h0);
        check("post_rst_round_key", round_key, 128'h0);

        // Request in IDLE is flagged and produces nothing.
        do_req('0, 4'd0, 1'b0);
        repeat (2) @(negedge clk);
        check("idle_req_err", 128'(err), 128'h1);
        check("idle_req_key_valid", 128'(key_valid), 128'h0);

        do_start(KEY_B);
        check("final_start_err", 128'(err), 128'h0);
        do_req(KEY_B_RK1, 4'd1, 1'b1);
        repeat (2) @(negedge clk);
        check("keyb_round_num", 128'(round_num), 128'd1);

        for (int i = 0; i < 10 && sb.size() != 0; i++) @(negedge clk);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL sb_drain actual=%0d pending required=0", sb.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
